// File: rtl/filtro_pkg.sv
// Shared definitions for the two-channel filter arbiter: state encoding,
// channel identifiers and parameter defaults.
package filtro_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic CH_A = 1'b0;
    localparam logic CH_B = 1'b1;

    localparam int DATA_W_DEF  = 12;
    localparam int TIMEOUT_DEF = 15;

endpackage

// File: rtl/filtro_wdog.sv
// Run-length watchdog for the filter arbiter: clears on grant, counts RUN
// cycles and flags the last allowed cycle so the job can be aborted.
module filtro_wdog #(
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic run,
    output logic expire
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (run) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Counter holds k-1 during the k-th RUN cycle.
    assign expire = run && (cnt_q == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/filtro_arbitro.sv
// Round-robin arbiter feeding two sample channels into one shared filter.
// Optional RUN watchdog with err_timeout port under FILTRO_ARB_TIMEOUT_EN.
//
// state | meaning
// IDLE  | waiting for a request; grants one channel per edge
// RUN   | filter busy for ch_sel; waits for filt_done (or watchdog)
module filtro_arbitro
    import filtro_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_a,
    input  logic              req_b,
    input  logic [DATA_W-1:0] dat_a,
    input  logic [DATA_W-1:0] dat_b,
    output logic              ack_a,
    output logic              ack_b,
    output logic              filt_start,
    output logic [DATA_W-1:0] filt_din,
    output logic              ch_sel,
    input  logic              filt_done,
    input  logic [DATA_W-1:0] filt_dout,
    output logic [DATA_W-1:0] out_a,
    output logic [DATA_W-1:0] out_b,
    output logic              vld_a,
    output logic              vld_b,
    output logic              busy
`ifdef FILTRO_ARB_TIMEOUT_EN
   ,output logic              err_timeout
`endif
);

    if (TIMEOUT < 1) begin : g_timeout_chk
        $error("filtro_arbitro: TIMEOUT must be at least 1");
    end

    state_t            state_q, state_d;
    logic              last_ch_q, last_ch_d;
    logic              ack_a_q, ack_a_d, ack_b_q, ack_b_d;
    logic              filt_start_q, filt_start_d;
    logic              vld_a_q, vld_a_d, vld_b_q, vld_b_d;
    logic              ch_sel_q, ch_sel_d;
    logic [DATA_W-1:0] filt_din_q, filt_din_d;
    logic [DATA_W-1:0] out_a_q, out_a_d, out_b_q, out_b_d;
    logic              grant_ch;

`ifdef FILTRO_ARB_TIMEOUT_EN
    logic err_q, err_d;
    logic wdog_expire;

    filtro_wdog #(.TIMEOUT(TIMEOUT)) u_wdog (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (filt_start_d),
        .run    (state_q == RUN),
        .expire (wdog_expire)
    );
`endif

    always_comb begin
        state_d      = state_q;
        last_ch_d    = last_ch_q;
        ack_a_d      = 1'b0;
        ack_b_d      = 1'b0;
        filt_start_d = 1'b0;
        vld_a_d      = 1'b0;
        vld_b_d      = 1'b0;
        ch_sel_d     = ch_sel_q;
        filt_din_d   = filt_din_q;
        out_a_d      = out_a_q;
        out_b_d      = out_b_q;
        grant_ch     = CH_A;
`ifdef FILTRO_ARB_TIMEOUT_EN
        err_d        = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (req_a || req_b) begin
                    // On a tie the channel that did not win last time goes.
                    if (req_a && req_b) begin
                        grant_ch = (last_ch_q == CH_A) ? CH_B : CH_A;
                    end else begin
                        grant_ch = req_b ? CH_B : CH_A;
                    end
                    state_d      = RUN;
                    last_ch_d    = grant_ch;
                    ch_sel_d     = grant_ch;
                    ack_a_d      = (grant_ch == CH_A);
                    ack_b_d      = (grant_ch == CH_B);
                    filt_start_d = 1'b1;
                    filt_din_d   = (grant_ch == CH_A) ? dat_a : dat_b;
                end
            end
            RUN: begin
                // A done seen while filt_start is still high belongs to the previous job.
                if (filt_done && !filt_start_q) begin
                    if (ch_sel_q == CH_A) begin
                        out_a_d = filt_dout;
                        vld_a_d = 1'b1;
                    end else begin
                        out_b_d = filt_dout;
                        vld_b_d = 1'b1;
                    end
                    state_d = IDLE;
                end
`ifdef FILTRO_ARB_TIMEOUT_EN
                else if (wdog_expire) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            last_ch_q    <= CH_B;
            ack_a_q      <= 1'b0;
            ack_b_q      <= 1'b0;
            filt_start_q <= 1'b0;
            vld_a_q      <= 1'b0;
            vld_b_q      <= 1'b0;
            ch_sel_q     <= CH_A;
            filt_din_q   <= '0;
            out_a_q      <= '0;
            out_b_q      <= '0;
        end else begin
            state_q      <= state_d;
            last_ch_q    <= last_ch_d;
            ack_a_q      <= ack_a_d;
            ack_b_q      <= ack_b_d;
            filt_start_q <= filt_start_d;
            vld_a_q      <= vld_a_d;
            vld_b_q      <= vld_b_d;
            ch_sel_q     <= ch_sel_d;
            filt_din_q   <= filt_din_d;
            out_a_q      <= out_a_d;
            out_b_q      <= out_b_d;
        end
    end

`ifdef FILTRO_ARB_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err_timeout = err_q;
`endif

    assign ack_a      = ack_a_q;
    assign ack_b      = ack_b_q;
    assign filt_start = filt_start_q;
    assign filt_din   = filt_din_q;
    assign ch_sel     = ch_sel_q;
    assign out_a      = out_a_q;
    assign out_b      = out_b_q;
    assign vld_a      = vld_a_q;
    assign vld_b      = vld_b_q;
    assign busy       = (state_q == RUN);

endmodule

// File: tb/tb_filtro_arbitro.sv
// Self-checking bench for filtro_arbitro; the watchdog scenario is built
// only when FILTRO_ARB_TIMEOUT_EN is defined.
module tb_filtro_arbitro;
    import filtro_pkg::*;

    localparam int DW = 12;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          req_a = 1'b0, req_b = 1'b0, filt_done = 1'b0;
    logic [DW-1:0] dat_a = '0, dat_b = '0, filt_dout = '0;
    logic          ack_a, ack_b, filt_start, ch_sel, vld_a, vld_b, busy;
    logic [DW-1:0] filt_din, out_a, out_b;
`ifdef FILTRO_ARB_TIMEOUT_EN
    logic          err_timeout;
`endif

    typedef struct {
        logic          ch;
        logic [DW-1:0] val;
    } exp_t;

    exp_t          exp_q[$];
    exp_t          mon_e;
    int            n_vec = 0;
    int            n_err = 0;
    logic [DW-1:0] model_a = '0, model_b = '0;

    filtro_arbitro #(.DATA_W(DW), .TIMEOUT(15)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_a      (req_a),
        .req_b      (req_b),
        .dat_a      (dat_a),
        .dat_b      (dat_b),
        .ack_a      (ack_a),
        .ack_b      (ack_b),
        .filt_start (filt_start),
        .filt_din   (filt_din),
        .ch_sel     (ch_sel),
        .filt_done  (filt_done),
        .filt_dout  (filt_dout),
        .out_a      (out_a),
        .out_b      (out_b),
        .vld_a      (vld_a),
        .vld_b      (vld_b),
        .busy       (busy)
`ifdef FILTRO_ARB_TIMEOUT_EN
       ,.err_timeout(err_timeout)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL tb_watchdog: simulation time limit reached, required completion");
        $fatal(1, "tb time limit");
    end

    // Scoreboard: every vld pulse must match the oldest queued result.
    always @(negedge clk) begin
        if (rst_n && (vld_a || vld_b)) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_vld: vld_a=%0b vld_b=%0b, required no pulse", vld_a, vld_b);
            end else begin
                mon_e = exp_q.pop_front();
                if ({vld_a, vld_b} !== ((mon_e.ch == CH_A) ? 2'b10 : 2'b01)) begin
                    n_err++;
                    $display("FAIL vld_channel: vld_a=%0b vld_b=%0b, required channel %0d", vld_a, vld_b, mon_e.ch);
                end
                n_vec++;
                if (mon_e.ch == CH_A) begin
                    if (out_a !== mon_e.val) begin
                        n_err++;
                        $display("FAIL out_a_value: got %h, required %h", out_a, mon_e.val);
                    end
                    model_a = mon_e.val;
                    n_vec++;
                    if (out_b !== model_b) begin
                        n_err++;
                        $display("FAIL out_b_held: got %h, required %h", out_b, model_b);
                    end
                end else begin
                    if (out_b !== mon_e.val) begin
                        n_err++;
                        $display("FAIL out_b_value: got %h, required %h", out_b, mon_e.val);
                    end
                    model_b = mon_e.val;
                    n_vec++;
                    if (out_a !== model_a) begin
                        n_err++;
                        $display("FAIL out_a_held: got %h, required %h", out_a, model_a);
                    end
                end
            end
        end
    end

    task automatic apply_reset;
        rst_n = 1'b0;
        req_a = 1'b0;
        req_b = 1'b0;
        filt_done = 1'b0;
        exp_q.delete();
        model_a = '0;
        model_b = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic wait_grant(output bit got);
        got = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (ack_a || ack_b) begin
                got = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset;
        #2 rst_n = 1'b0;
        #1;
        n_vec++;
        if ({ack_a, ack_b, filt_start, vld_a, vld_b, busy, ch_sel} !== 7'b0) begin
            n_err++;
            $display("FAIL reset_ctrl: ack_a,ack_b,start,vld_a,vld_b,busy,ch_sel=%b, required 0000000",
                     {ack_a, ack_b, filt_start, vld_a, vld_b, busy, ch_sel});
        end
        n_vec++;
        if ({filt_din, out_a, out_b} !== '0) begin
            n_err++;
            $display("FAIL reset_data: filt_din=%h out_a=%h out_b=%h, required 0", filt_din, out_a, out_b);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_single;
        bit got;
        apply_reset();
        req_a = 1'b1;
        dat_a = 12'h123;
        wait_grant(got);
        n_vec++;
        if (!got) begin n_err++; $display("FAIL single_grant: no ack within bound, required ack_a"); end
        n_vec++;
        if ({ack_a, ack_b, filt_start, busy} !== 4'b1011) begin
            n_err++;
            $display("FAIL single_ack: ack_a,ack_b,start,busy=%b, required 1011", {ack_a, ack_b, filt_start, busy});
        end
        n_vec++;
        if (filt_din !== 12'h123 || ch_sel !== CH_A) begin
            n_err++;
            $display("FAIL single_din: filt_din=%h ch_sel=%0b, required 123/0", filt_din, ch_sel);
        end
        req_a = 1'b0;
        @(negedge clk);
        n_vec++;
        if ({ack_a, filt_start, busy} !== 3'b001) begin
            n_err++;
            $display("FAIL single_pulse_width: ack_a,start,busy=%b, required 001", {ack_a, filt_start, busy});
        end
        filt_done = 1'b1;
        filt_dout = 12'h456;
        exp_q.push_back('{CH_A, 12'h456});
        @(negedge clk);
        filt_done = 1'b0;
        n_vec++;
        if (out_a !== 12'h456 || out_b !== '0 || vld_a !== 1'b1 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL single_result: out_a=%h out_b=%h vld_a=%0b busy=%0b, required 456/000/1/0",
                     out_a, out_b, vld_a, busy);
        end
        @(negedge clk);
        n_vec++;
        if (vld_a !== 1'b0 || out_a !== 12'h456) begin
            n_err++;
            $display("FAIL single_vld_width: vld_a=%0b out_a=%h, required 0/456", vld_a, out_a);
        end
    endtask

    task automatic test_round_robin;
        bit            got;
        logic          exp_ch;
        logic [DW-1:0] exp_din;
        apply_reset();
        dat_a = 12'h0A5;
        dat_b = 12'h0B7;
        req_a = 1'b1;
        req_b = 1'b1;
        for (int i = 0; i < 4; i++) begin
            exp_ch  = (i % 2 == 1) ? CH_B : CH_A;
            exp_din = (exp_ch == CH_B) ? 12'h0B7 : 12'h0A5;
            wait_grant(got);
            n_vec++;
            if (!got) begin n_err++; $display("FAIL rr_grant_%0d: no ack within bound, required a grant", i); end
            n_vec++;
            if ({ack_a, ack_b} !== ((exp_ch == CH_A) ? 2'b10 : 2'b01) || ch_sel !== exp_ch) begin
                n_err++;
                $display("FAIL rr_order_%0d: ack_a,ack_b=%b ch_sel=%0b, required channel %0d",
                         i, {ack_a, ack_b}, ch_sel, exp_ch);
            end
            repeat (3) @(negedge clk);
            n_vec++;
            if (filt_din !== exp_din || ch_sel !== exp_ch) begin
                n_err++;
                $display("FAIL rr_hold_%0d: filt_din=%h ch_sel=%0b, required %h/%0d", i, filt_din, ch_sel, exp_din, exp_ch);
            end
            filt_done = 1'b1;
            filt_dout = DW'(12'h300 + i);
            exp_q.push_back('{exp_ch, DW'(12'h300 + i)});
            @(negedge clk);
            filt_done = 1'b0;
        end
        req_a = 1'b0;
        req_b = 1'b0;
        @(negedge clk);
        n_vec++;
        if (out_a !== 12'h302 || out_b !== 12'h303) begin
            n_err++;
            $display("FAIL rr_final: out_a=%h out_b=%h, required 302/303", out_a, out_b);
        end
    endtask

    task automatic test_req_during_run;
        bit got;
        apply_reset();
        req_a = 1'b1;
        dat_a = 12'h1C3;
        wait_grant(got);
        n_vec++;
        if (!got || ack_a !== 1'b1) begin
            n_err++;
            $display("FAIL hold_grant_a: got=%0b ack_a=%0b, required 1/1", got, ack_a);
        end
        req_a = 1'b0;
        req_b = 1'b1;
        dat_b = 12'h2D4;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            n_vec++;
            if (ack_b !== 1'b0 || busy !== 1'b1) begin
                n_err++;
                $display("FAIL hold_no_ack_b_%0d: ack_b=%0b busy=%0b, required 0/1", k, ack_b, busy);
            end
        end
        filt_done = 1'b1;
        filt_dout = 12'h5E6;
        exp_q.push_back('{CH_A, 12'h5E6});
        @(negedge clk);
        filt_done = 1'b0;
        n_vec++;
        if (vld_a !== 1'b1 || ack_b !== 1'b0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL hold_done_a: vld_a=%0b ack_b=%0b busy=%0b, required 1/0/0", vld_a, ack_b, busy);
        end
        @(negedge clk);
        n_vec++;
        if (ack_b !== 1'b1 || filt_din !== 12'h2D4 || ch_sel !== CH_B) begin
            n_err++;
            $display("FAIL hold_grant_b: ack_b=%0b filt_din=%h ch_sel=%0b, required 1/2d4/1", ack_b, filt_din, ch_sel);
        end
        req_b = 1'b0;
        @(negedge clk);
        filt_done = 1'b1;
        filt_dout = 12'h6F7;
        exp_q.push_back('{CH_B, 12'h6F7});
        @(negedge clk);
        filt_done = 1'b0;
        n_vec++;
        if (out_a !== 12'h5E6 || out_b !== 12'h6F7) begin
            n_err++;
            $display("FAIL hold_outputs: out_a=%h out_b=%h, required 5e6/6f7", out_a, out_b);
        end
    endtask

    task automatic test_done_ignored;
        apply_reset();
        filt_done = 1'b1;
        filt_dout = 12'hBAD;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_vec++;
            if (busy !== 1'b0 || vld_a !== 1'b0 || vld_b !== 1'b0 || out_a !== '0) begin
                n_err++;
                $display("FAIL idle_done_%0d: busy=%0b vld_a=%0b vld_b=%0b out_a=%h, required 0/0/0/000",
                         k, busy, vld_a, vld_b, out_a);
            end
        end
        req_a = 1'b1;
        dat_a = 12'h0C1;
        @(negedge clk);
        req_a = 1'b0;
        n_vec++;
        if (filt_start !== 1'b1 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL start_done_grant: start=%0b busy=%0b, required 1/1", filt_start, busy);
        end
        @(negedge clk);
        filt_done = 1'b0;
        n_vec++;
        if (busy !== 1'b1 || vld_a !== 1'b0 || out_a !== '0) begin
            n_err++;
            $display("FAIL start_done_ignored: busy=%0b vld_a=%0b out_a=%h, required 1/0/000", busy, vld_a, out_a);
        end
        @(negedge clk);
        filt_done = 1'b1;
        filt_dout = 12'h0D2;
        exp_q.push_back('{CH_A, 12'h0D2});
        @(negedge clk);
        filt_done = 1'b0;
        n_vec++;
        if (vld_a !== 1'b1 || out_a !== 12'h0D2) begin
            n_err++;
            $display("FAIL start_done_later: vld_a=%0b out_a=%h, required 1/0d2", vld_a, out_a);
        end
    endtask

    task automatic test_reset_in_run;
        bit got;
        apply_reset();
        req_a = 1'b1;
        dat_a = 12'h111;
        wait_grant(got);
        req_a = 1'b0;
        @(negedge clk);
        filt_done = 1'b1;
        filt_dout = 12'h222;
        exp_q.push_back('{CH_A, 12'h222});
        @(negedge clk);
        filt_done = 1'b0;
        req_a = 1'b1;
        dat_a = 12'h3A1;
        wait_grant(got);
        n_vec++;
        if (!got || filt_din !== 12'h3A1) begin
            n_err++;
            $display("FAIL rstrun_grant: got=%0b filt_din=%h, required 1/3a1", got, filt_din);
        end
        req_a = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        model_a = '0;
        model_b = '0;
        #1;
        n_vec++;
        if ({ack_a, ack_b, filt_start, vld_a, vld_b, busy, ch_sel} !== 7'b0 ||
            {filt_din, out_a, out_b} !== '0) begin
            n_err++;
            $display("FAIL rstrun_clear: ctrl=%b filt_din=%h out_a=%h out_b=%h, required all 0",
                     {ack_a, ack_b, filt_start, vld_a, vld_b, busy, ch_sel}, filt_din, out_a, out_b);
        end
        filt_done = 1'b1;
        filt_dout = 12'h777;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        filt_done = 1'b0;
        n_vec++;
        if (busy !== 1'b0 || vld_a !== 1'b0 || out_a !== '0) begin
            n_err++;
            $display("FAIL rstrun_late_done: busy=%0b vld_a=%0b out_a=%h, required 0/0/000", busy, vld_a, out_a);
        end
    endtask

`ifdef FILTRO_ARB_TIMEOUT_EN
    task automatic test_timeout;
        bit got;
        int run_cnt;
        apply_reset();
        req_a = 1'b1;
        dat_a = 12'h0AA;
        wait_grant(got);
        req_a = 1'b0;
        run_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            if (!busy) break;
            run_cnt++;
            n_vec++;
            if (err_timeout !== 1'b0) begin
                n_err++;
                $display("FAIL to_early: err_timeout=1 in run cycle %0d, required 0", run_cnt);
            end
            @(negedge clk);
        end
        n_vec++;
        if (run_cnt != 15 || err_timeout !== 1'b1 || vld_a !== 1'b0 || out_a !== '0) begin
            n_err++;
            $display("FAIL to_abort: run_cycles=%0d err=%0b vld_a=%0b out_a=%h, required 15/1/0/000",
                     run_cnt, err_timeout, vld_a, out_a);
        end
        req_b = 1'b1;
        dat_b = 12'h0BB;
        wait_grant(got);
        n_vec++;
        if (!got || ack_b !== 1'b1) begin
            n_err++;
            $display("FAIL to_regrant: got=%0b ack_b=%0b, required 1/1", got, ack_b);
        end
        req_b = 1'b0;
        repeat (14) @(negedge clk);
        filt_done = 1'b1;
        filt_dout = 12'h0EE;
        exp_q.push_back('{CH_B, 12'h0EE});
        @(negedge clk);
        filt_done = 1'b0;
        n_vec++;
        if (err_timeout !== 1'b0 || vld_b !== 1'b1 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL to_done_wins: err=%0b vld_b=%0b busy=%0b, required 0/1/0", err_timeout, vld_b, busy);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_req_during_run();
        test_done_ignored();
        test_reset_in_run();
`ifdef FILTRO_ARB_TIMEOUT_EN
        test_timeout();
`endif
        repeat (3) @(negedge clk);
        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL pending_results: %0d results never produced, required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
